capture_ctrl: RTL and testbench
===============================

// Module: capture_ctrl
// PURPOSE
//  Capture controller downstream of the protocol trigger receivers (SPI/UART).
//  Drives a circular sample RAM: writes pre-trigger samples until armed, accepts one
//  trigger pulse, writes trig_pos post-trigger samples, then flags capture complete.
//  Reports trig_addr, the address of the oldest valid sample, for readout.
// PARAMETERS
//  DEPTH  512  sample RAM entries; power of two.
//  AW     9    address width; log2(DEPTH).
// PORTS
//  clk               in   1   100MHz system clock
//  rst_n             in   1   asynchronous active-low reset
//  run               in   1   level; capture enabled while high (command register)
//  capture_done      in   1   level; host-visible done bit (set by set_capture_done)
//  wrt_smpl          in   1   1-clk strobe; a decimated sample is valid this cycle
//  prot_trig         in   1   1-clk pulse; OR of protocol receiver triggers (e.g. SPItrig)
//  trig_pos          in   AW  number of samples to store after the trigger
//  we                out  1   RAM write enable, combinational, same cycle as wrt_smpl
//  waddr             out  AW  RAM write address
//  trig_addr         out  AW  address of oldest sample, valid while in DONE
//  armed             out  1   enough pre-trigger samples held; triggers accepted
//  triggered         out  1   trigger accepted, post-trigger sampling in progress/done
//  set_capture_done  out  1   1-clk pulse when the capture completes
// BEHAVIOUR
//  Reset: state=IDLE; waddr, trig_addr, smpl_cnt, post_cnt = 0; armed, triggered,
//   set_capture_done = 0. we is 0 outside WAIT_TRG/SAMP_POST.
//  FSM states: IDLE, WAIT_TRG, SAMP_POST, DONE.
//  IDLE: waddr, smpl_cnt, post_cnt cleared. run & ~capture_done -> WAIT_TRG.
//  WAIT_TRG: on wrt_smpl: we=1; waddr increments after the write; smpl_cnt increments.
//   smpl_cnt is AW+1 bits and saturates at DEPTH.
//   armed (registered) = (smpl_cnt + trig_pos_c) >= DEPTH, compared at AW+2 bits.
//   prot_trig & armed -> SAMP_POST; triggered set next clk. prot_trig & ~armed: ignored.
//   Simultaneous wrt_smpl & accepted prot_trig: that sample is written as pre-trigger.
//  SAMP_POST: on wrt_smpl: we=1; waddr increments; post_cnt increments.
//   When post_cnt reaches trig_pos_c -> DONE; last write is the one making them equal.
//   trig_pos_c==0: SAMP_POST exits on its first clk with no writes.
//  DONE entry: set_capture_done=1 for exactly one clk; trig_addr <= waddr, the next
//   address to write and hence the oldest sample. No writes in DONE.
//   triggered and armed stay high in DONE. DONE -> IDLE when run==0.
//  trig_pos_c = min(trig_pos, DEPTH-1); trig_pos is sampled continuously.
//   Software holds it stable while run=1.
//  Wrap: waddr increments modulo DEPTH (DEPTH-1 -> 0); no full/overflow flag.
//   The oldest data is overwritten while waiting for the trigger.
//  Abort: run==0 in WAIT_TRG or SAMP_POST -> IDLE next clk.
//   No set_capture_done on abort; armed and triggered clear.
//  Reset mid-capture: everything returns to reset values immediately (async).
//  Latency: prot_trig to triggered = 1 clk. Last post write to set_capture_done = 1 clk.
// TESTING
//  1 Reset with all inputs toggling -> every output 0, waddr=0.
//  2 run=1, trig_pos=500, prot_trig after 5 samples -> ignored, triggered=0.
//    armed rises the clk after the 12th sample.
//  3 trig_pos=100, trigger after 412 samples -> exactly 100 more we pulses, then
//    set_capture_done 1 clk; trig_addr = waddr = (412+100)%512 = 0.
//  4 1000 samples with no trigger -> waddr wraps 511->0; smpl_cnt holds 512; armed stays 1.
//  5 trig_pos=0, trigger once armed -> no further we; set_capture_done within 2 clks.
//  6 Drop run at post_cnt=30 -> IDLE next clk; set_capture_done never pulses.
//    triggered and armed clear.

Source files
------------

// File: rtl/capture_if.sv
// Capture controller bus: host command/status, sample strobe and trigger inputs,
// and the sample-RAM write port plus capture status outputs.
interface capture_if #(
  parameter int AW = 9
) ();

  // Inputs to the capture controller
  logic          run;
  logic          capture_done;
  logic          wrt_smpl;
  logic          prot_trig;
  logic [AW-1:0] trig_pos;

  // Outputs from the capture controller
  logic          we;
  logic [AW-1:0] waddr;
  logic [AW-1:0] trig_addr;
  logic          armed;
  logic          triggered;
  logic          set_capture_done;

  // Host / stimulus side
  modport master (
    output run, capture_done, wrt_smpl, prot_trig, trig_pos,
    input  we, waddr, trig_addr, armed, triggered, set_capture_done
  );

  // Capture controller side
  modport slave (
    input  run, capture_done, wrt_smpl, prot_trig, trig_pos,
    output we, waddr, trig_addr, armed, triggered, set_capture_done
  );

endinterface

// File: rtl/capture_ctrl.sv
// Capture controller for a circular sample RAM.
// Fills the RAM with pre-trigger samples until enough are held (armed), accepts one
// protocol trigger, stores trig_pos post-trigger samples, then pulses
// set_capture_done and reports trig_addr, the address of the oldest sample.
module capture_ctrl #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic     clk,
  input  logic     rst_n,
  capture_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TRG,
    SAMP_POST,
    DONE
  } state_e;

  // Largest usable post-trigger count: one slot must hold at least one pre-trigger sample.
  localparam logic [AW-1:0] TP_MAX    = AW'(DEPTH - 1);
  // Pre-trigger sample counter saturates once the whole RAM holds valid data.
  localparam logic [AW:0]   CNT_MAX   = (AW+1)'(DEPTH);
  // Armed threshold, compared at AW+2 bits so count + trig_pos cannot overflow.
  localparam logic [AW+1:0] ARM_LIMIT = (AW+2)'(DEPTH);

  state_e        state_q;
  logic [AW-1:0] waddr_q;
  logic [AW-1:0] waddr_d;
  logic [AW-1:0] trig_addr_q;
  logic [AW:0]   smpl_cnt_q;
  logic [AW:0]   smpl_cnt_d;
  logic [AW-1:0] post_cnt_q;
  logic [AW-1:0] post_cnt_d;
  logic          armed_q;
  logic          armed_d;
  logic          triggered_q;
  logic          set_done_q;

  logic [AW-1:0] trig_pos_c;
  logic          post_pending;
  logic          wr_pre;
  logic          wr_post;
  logic          post_last;
  logic          we;

  // Write qualification and next values of the address/counters.
  // NOTE: every signal in this block is assigned on every path, so no latch is inferred.
  always_comb begin
    trig_pos_c   = (bus.trig_pos > TP_MAX) ? TP_MAX : bus.trig_pos;
    post_pending = (post_cnt_q < trig_pos_c);

    // Writes only while capturing and run is still high; an aborting cycle writes nothing.
    wr_pre  = (state_q == WAIT_TRG)  && bus.run && bus.wrt_smpl;
    wr_post = (state_q == SAMP_POST) && bus.run && bus.wrt_smpl && post_pending;
    we      = wr_pre || wr_post;

    // Address wraps naturally at DEPTH because it is exactly AW bits wide.
    waddr_d    = we ? (waddr_q + AW'(1)) : waddr_q;
    smpl_cnt_d = (wr_pre && (smpl_cnt_q != CNT_MAX)) ? (smpl_cnt_q + (AW+1)'(1)) : smpl_cnt_q;
    post_cnt_d = wr_post ? (post_cnt_q + AW'(1)) : post_cnt_q;

    // The write that makes post_cnt equal to trig_pos_c is the last one.
    post_last = wr_post && (post_cnt_d >= trig_pos_c);

    armed_d = (({1'b0, smpl_cnt_d} + {2'b00, trig_pos_c}) >= ARM_LIMIT);
  end

  // Capture FSM with registered status outputs.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      waddr_q     <= '0;
      trig_addr_q <= '0;
      smpl_cnt_q  <= '0;
      post_cnt_q  <= '0;
      armed_q     <= 1'b0;
      triggered_q <= 1'b0;
      set_done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          waddr_q     <= '0;
          smpl_cnt_q  <= '0;
          post_cnt_q  <= '0;
          armed_q     <= 1'b0;
          triggered_q <= 1'b0;
          set_done_q  <= 1'b0;
          if (bus.run && !bus.capture_done) begin
            state_q <= WAIT_TRG;
          end
        end

        WAIT_TRG: begin
          if (!bus.run) begin
            state_q     <= IDLE;
            waddr_q     <= '0;
            smpl_cnt_q  <= '0;
            armed_q     <= 1'b0;
            triggered_q <= 1'b0;
          end else begin
            waddr_q    <= waddr_d;
            smpl_cnt_q <= smpl_cnt_d;
            armed_q    <= armed_d;
            // A sample strobed alongside the accepted trigger is still pre-trigger.
            if (bus.prot_trig && armed_q) begin
              state_q     <= SAMP_POST;
              triggered_q <= 1'b1;
            end
          end
        end

        SAMP_POST: begin
          if (!bus.run) begin
            state_q     <= IDLE;
            waddr_q     <= '0;
            smpl_cnt_q  <= '0;
            post_cnt_q  <= '0;
            armed_q     <= 1'b0;
            triggered_q <= 1'b0;
          end else begin
            waddr_q    <= waddr_d;
            post_cnt_q <= post_cnt_d;
            // Nothing left to store (trig_pos_c == 0) or the last write just landed.
            if (!post_pending || post_last) begin
              state_q     <= DONE;
              set_done_q  <= 1'b1;
              // The next address to write holds the oldest sample in the ring.
              trig_addr_q <= waddr_d;
            end
          end
        end

        DONE: begin
          set_done_q <= 1'b0;
          if (!bus.run) begin
            state_q     <= IDLE;
            waddr_q     <= '0;
            smpl_cnt_q  <= '0;
            post_cnt_q  <= '0;
            armed_q     <= 1'b0;
            triggered_q <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.we               = we;
  assign bus.waddr            = waddr_q;
  assign bus.trig_addr        = trig_addr_q;
  assign bus.armed            = armed_q;
  assign bus.triggered        = triggered_q;
  assign bus.set_capture_done = set_done_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Testbench for capture_ctrl: directed scenarios plus randomized captures checked
// against a sample-counting reference model.
module tb_capture_ctrl;

  localparam int DEPTH = 512;
  localparam int AW    = 9;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  capture_if #(.AW(AW)) cif ();

  capture_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (cif.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: counts of samples, not FSM states.
  bit m_cap;      // capture in progress (waiting for trigger or storing post samples)
  bit m_trig;     // trigger accepted
  bit m_done;     // capture complete, waiting for run to drop
  bit m_pulse;    // completion pulse expected this cycle
  int m_writes;   // RAM writes since capture start
  int m_pre;      // pre-trigger samples written
  int m_post;     // post-trigger samples written
  int m_taddr;    // expected oldest-sample address
  int tp;         // trig_pos currently applied

  bit prev_wr;
  int obs_we_cnt;
  int exp_we_cnt;
  int obs_done_cnt;
  bit obs_we;
  bit exp_we;

  function automatic bit m_armed();
    int held;
    held = (m_pre > DEPTH) ? DEPTH : m_pre;
    return (m_cap || m_done) && ((held + tp) >= DEPTH);
  endfunction

  task automatic model_reset();
    m_cap = 0; m_trig = 0; m_done = 0; m_pulse = 0;
    m_writes = 0; m_pre = 0; m_post = 0; m_taddr = 0;
    prev_wr = 0;
  endtask

  // One clock: apply inputs just after a rising edge, sample we mid-cycle,
  // advance the model at the edge, return 1 time unit after the edge.
  task automatic step(input bit wr, input bit trig);
    bit e_we;
    bit arm_now;
    cif.wrt_smpl  = wr;
    cif.prot_trig = trig;
    e_we = wr && cif.run && m_cap && (!m_trig || (m_post < tp));
    @(negedge clk);
    obs_we = cif.we;
    exp_we = e_we;
    if (cif.we) obs_we_cnt++;
    if (e_we) exp_we_cnt++;
    if (cif.set_capture_done) obs_done_cnt++;
    @(posedge clk);
    arm_now = m_armed();
    m_pulse = 0;
    if (!cif.run) begin
      m_cap = 0; m_trig = 0; m_done = 0;
      m_writes = 0; m_pre = 0; m_post = 0;
    end else if (!m_cap && !m_done) begin
      if (!cif.capture_done) m_cap = 1;
    end else if (m_cap && !m_trig) begin
      if (wr) begin
        m_writes++;
        m_pre++;
      end
      if (trig && arm_now) m_trig = 1;
    end else if (m_cap) begin
      if ((m_post < tp) && wr) begin
        m_writes++;
        m_post++;
      end
      if (m_post >= tp) begin
        m_cap   = 0;
        m_done  = 1;
        m_pulse = 1;
        m_taddr = m_writes % DEPTH;
      end
    end
    #1;
    cif.wrt_smpl  = 1'b0;
    cif.prot_trig = 1'b0;
    prev_wr = wr;
  endtask

  task automatic start_run(input int trig_pos);
    tp = trig_pos;
    cif.trig_pos = AW'(trig_pos);
    cif.capture_done = 1'b0;
    cif.run = 1'b1;
    step(0, 0);
  endtask

  task automatic stop_run();
    cif.capture_done = m_done;
    cif.run = 1'b0;
    step(0, 0);
    cif.capture_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      cif.run          = 1'($urandom);
      cif.capture_done = 1'($urandom);
      cif.wrt_smpl     = 1'($urandom);
      cif.prot_trig    = 1'($urandom);
      cif.trig_pos     = AW'($urandom);
      @(negedge clk);
      n_vec++;
      if ({cif.we, cif.armed, cif.triggered, cif.set_capture_done} !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_flags: got we/armed/trig/done=%b want 0000",
                 {cif.we, cif.armed, cif.triggered, cif.set_capture_done});
      end
      n_vec++;
      if (cif.waddr !== '0) begin
        n_err++;
        $display("FAIL reset_waddr: got %0d want 0", cif.waddr);
      end
      n_vec++;
      if (cif.trig_addr !== '0) begin
        n_err++;
        $display("FAIL reset_trig_addr: got %0d want 0", cif.trig_addr);
      end
    end
    cif.run = 1'b0; cif.capture_done = 1'b0; cif.wrt_smpl = 1'b0;
    cif.prot_trig = 1'b0; cif.trig_pos = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_async_reset();
    start_run(500);
    repeat (20) step(1, 0);
    step(0, 0);
    step(0, 1);
    repeat (3) step(1, 0);
    n_vec++;
    if (cif.triggered !== m_trig) begin
      n_err++;
      $display("FAIL async_pre_triggered: got %b want %b", cif.triggered, m_trig);
    end
    #2;
    cif.wrt_smpl = 1'b1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({cif.we, cif.armed, cif.triggered, cif.set_capture_done} !== 4'b0000) begin
      n_err++;
      $display("FAIL async_reset_flags: got %b want 0000",
               {cif.we, cif.armed, cif.triggered, cif.set_capture_done});
    end
    n_vec++;
    if (cif.waddr !== '0) begin
      n_err++;
      $display("FAIL async_reset_waddr: got %0d want 0", cif.waddr);
    end
    cif.wrt_smpl = 1'b0;
    cif.run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_arm_threshold();
    start_run(500);
    repeat (5) step(1, 0);
    step(0, 0);
    step(0, 1);
    n_vec++;
    if (cif.triggered !== 1'b0) begin
      n_err++;
      $display("FAIL early_trig_ignored: got triggered=%b want 0", cif.triggered);
    end
    repeat (6) step(1, 0);
    step(0, 0);
    n_vec++;
    if (cif.armed !== 1'b0) begin
      n_err++;
      $display("FAIL armed_after_11: got %b want 0", cif.armed);
    end
    step(1, 0);
    step(0, 0);
    n_vec++;
    if (cif.armed !== 1'b1) begin
      n_err++;
      $display("FAIL armed_after_12: got %b want 1", cif.armed);
    end
    stop_run();
  endtask

  task automatic test_post_capture();
    int we_base;
    int done_base;
    start_run(100);
    repeat (412) step(1, 0);
    step(0, 0);
    step(0, 1);
    n_vec++;
    if (cif.triggered !== 1'b1) begin
      n_err++;
      $display("FAIL post_triggered: got %b want 1", cif.triggered);
    end
    we_base = obs_we_cnt;
    done_base = obs_done_cnt;
    for (int i = 0; i < 100; i++) begin
      step(1, 0);
      if (i == 98) begin
        n_vec++;
        if (cif.set_capture_done !== 1'b0) begin
          n_err++;
          $display("FAIL post_early_done: got %b want 0", cif.set_capture_done);
        end
      end
    end
    n_vec++;
    if (cif.set_capture_done !== 1'b1) begin
      n_err++;
      $display("FAIL post_done_pulse: got %b want 1", cif.set_capture_done);
    end
    n_vec++;
    if (cif.trig_addr !== AW'(0) || cif.waddr !== AW'(0)) begin
      n_err++;
      $display("FAIL post_trig_addr: got trig_addr=%0d waddr=%0d want 0/0",
               cif.trig_addr, cif.waddr);
    end
    repeat (3) step(1, 0);
    n_vec++;
    if (cif.set_capture_done !== 1'b0) begin
      n_err++;
      $display("FAIL post_done_one_clk: got %b want 0", cif.set_capture_done);
    end
    n_vec++;
    if ((obs_we_cnt - we_base) !== 100) begin
      n_err++;
      $display("FAIL post_we_count: got %0d want 100", obs_we_cnt - we_base);
    end
    n_vec++;
    if ((obs_done_cnt - done_base) !== 1) begin
      n_err++;
      $display("FAIL post_done_count: got %0d want 1", obs_done_cnt - done_base);
    end
    n_vec++;
    if (cif.armed !== 1'b1 || cif.triggered !== 1'b1) begin
      n_err++;
      $display("FAIL done_status: got armed=%b triggered=%b want 1/1", cif.armed, cif.triggered);
    end
    stop_run();
    n_vec++;
    if (cif.triggered !== 1'b0 || cif.waddr !== '0) begin
      n_err++;
      $display("FAIL done_to_idle: got triggered=%b waddr=%0d want 0/0", cif.triggered, cif.waddr);
    end
  endtask

  task automatic test_wrap();
    start_run(10);
    for (int i = 1; i <= 1000; i++) begin
      step(1, 0);
      n_vec++;
      if (cif.waddr !== AW'(i % DEPTH)) begin
        n_err++;
        $display("FAIL wrap_waddr: sample %0d got %0d want %0d", i, cif.waddr, i % DEPTH);
      end
      if ($urandom_range(0, 7) == 0) begin
        step(0, 0);
        if (i >= 503) begin
          n_vec++;
          if (cif.armed !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_armed: sample %0d got %b want 1", i, cif.armed);
          end
        end
      end
    end
    step(0, 0);
    n_vec++;
    if (cif.armed !== 1'b1 || cif.triggered !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_end: got armed=%b triggered=%b want 1/0", cif.armed, cif.triggered);
    end
    stop_run();
  endtask

  task automatic test_trig_pos_zero();
    int we_base;
    int done_base;
    start_run(0);
    repeat (512) step(1, 0);
    step(0, 0);
    n_vec++;
    if (cif.armed !== 1'b1) begin
      n_err++;
      $display("FAIL zero_armed: got %b want 1", cif.armed);
    end
    step(0, 1);
    we_base = obs_we_cnt;
    done_base = obs_done_cnt;
    step(1, 0);
    n_vec++;
    if (cif.set_capture_done !== 1'b1) begin
      n_err++;
      $display("FAIL zero_done_pulse: got %b want 1", cif.set_capture_done);
    end
    repeat (2) step(1, 0);
    n_vec++;
    if ((obs_we_cnt - we_base) !== 0) begin
      n_err++;
      $display("FAIL zero_no_writes: got %0d want 0", obs_we_cnt - we_base);
    end
    n_vec++;
    if ((obs_done_cnt - done_base) !== 1 || cif.trig_addr !== AW'(0)) begin
      n_err++;
      $display("FAIL zero_done: got pulses=%0d trig_addr=%0d want 1/0",
               obs_done_cnt - done_base, cif.trig_addr);
    end
    stop_run();
  endtask

  task automatic test_abort();
    int done_base;
    start_run(100);
    repeat (412) step(1, 0);
    step(0, 0);
    step(0, 1);
    repeat (30) step(1, 0);
    done_base = obs_done_cnt;
    cif.run = 1'b0;
    step(0, 0);
    n_vec++;
    if (cif.triggered !== 1'b0 || cif.armed !== 1'b0) begin
      n_err++;
      $display("FAIL abort_status: got armed=%b triggered=%b want 0/0", cif.armed, cif.triggered);
    end
    repeat (4) step(1, 0);
    n_vec++;
    if ((obs_done_cnt - done_base) !== 0 || obs_we !== 1'b0) begin
      n_err++;
      $display("FAIL abort_no_done: got pulses=%0d we=%b want 0/0",
               obs_done_cnt - done_base, obs_we);
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 6; r++) begin
      int  abort_at;
      bit  wr;
      bit  trig;
      bit  aborted;
      int  tpv;
      tpv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(380, 511);
      abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(50, 800) : -1;
      aborted = 0;
      start_run(tpv);
      for (int c = 0; c < 4000 && !m_done && !aborted; c++) begin
        wr   = ($urandom_range(0, 99) < 60);
        trig = !prev_wr && ($urandom_range(0, 99) < 3);
        if (c == abort_at) begin
          cif.run = 1'b0;
          aborted = 1;
        end
        step(wr, trig);
        n_vec++;
        if (obs_we !== exp_we) begin
          n_err++;
          $display("FAIL rand_we: round %0d cycle %0d got %b want %b", r, c, obs_we, exp_we);
        end
        n_vec++;
        if (cif.waddr !== AW'(m_writes % DEPTH)) begin
          n_err++;
          $display("FAIL rand_waddr: round %0d cycle %0d got %0d want %0d",
                   r, c, cif.waddr, m_writes % DEPTH);
        end
        n_vec++;
        if (cif.triggered !== m_trig || cif.set_capture_done !== m_pulse) begin
          n_err++;
          $display("FAIL rand_status: round %0d cycle %0d got trig=%b done=%b want %b/%b",
                   r, c, cif.triggered, cif.set_capture_done, m_trig, m_pulse);
        end
        if (!wr) begin
          n_vec++;
          if (cif.armed !== m_armed()) begin
            n_err++;
            $display("FAIL rand_armed: round %0d cycle %0d got %b want %b",
                     r, c, cif.armed, m_armed());
          end
        end
      end
      if (!aborted) begin
        n_vec++;
        if (!m_done) begin
          n_err++;
          $display("FAIL rand_timeout: round %0d capture did not complete", r);
        end else if (cif.trig_addr !== AW'(m_taddr)) begin
          n_err++;
          $display("FAIL rand_trig_addr: round %0d got %0d want %0d", r, cif.trig_addr, m_taddr);
        end
      end
      stop_run();
    end
  endtask

  initial begin
    cif.run = 1'b0;
    cif.capture_done = 1'b0;
    cif.wrt_smpl = 1'b0;
    cif.prot_trig = 1'b0;
    cif.trig_pos = '0;
    tp = 0;
    obs_we_cnt = 0;
    exp_we_cnt = 0;
    obs_done_cnt = 0;
    model_reset();
    test_reset();
    test_async_reset();
    test_arm_threshold();
    test_post_capture();
    test_wrap();
    test_trig_pos_zero();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
